// File: rtl/fsab_arb2_pkg.sv
// Shared FSAB field widths, request encodings and arbiter state type.
package fsab_arb2_pkg;

  localparam int FSAB_REQ_HI  = 0;
  localparam int FSAB_DID_HI  = 3;
  localparam int FSAB_ADDR_HI = 30;
  localparam int FSAB_LEN_HI  = 3;
  localparam int FSAB_DATA_HI = 63;
  localparam int FSAB_MASK_HI = 7;

  localparam logic [FSAB_REQ_HI:0] FSAB_READ  = 1'b0;
  localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = 1'b1;

  localparam logic [FSAB_LEN_HI:0] LEN_ZERO = 4'd0;
  localparam logic [FSAB_LEN_HI:0] LEN_ONE  = 4'd1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // A zero length counts as one beat, so only writes longer than one beat lock the bus.
  function automatic logic is_multi_beat(input logic [FSAB_REQ_HI:0] mode,
                                         input logic [FSAB_LEN_HI:0] len);
    logic multi_s;
    if ((mode == FSAB_WRITE) && (len > LEN_ONE)) begin
      multi_s = 1'b1;
    end else begin
      multi_s = 1'b0;
    end
    return multi_s;
  endfunction

endpackage

// File: rtl/fsab_arb2_credit_ctr.sv
// Downstream request credit counter with a sticky over-return error flag.
module fsab_credit_ctr
  import fsab_arb2_pkg::*;
#(
  parameter int unsigned CREDITS = 4
) (
  input  logic       fclk,
  input  logic       fclk_rst_b,
  input  logic       consume,
  input  logic       credit_ret,
  output logic [3:0] credits,
  output logic       credit_err
);

  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  logic [3:0] credits_r;
  logic [3:0] credits_nxt_s;
  logic       credit_err_r;
  logic       credit_err_nxt_s;

  // Credit and error state registers.
  always_ff @(posedge fclk or negedge fclk_rst_b) begin
    if (!fclk_rst_b) begin
      credits_r    <= CRED_MAX;
      credit_err_r <= 1'b0;
    end else begin
      credits_r    <= credits_nxt_s;
      credit_err_r <= credit_err_nxt_s;
    end
  end

  // A start and a return in the same cycle cancel out.
  always_comb begin
    credits_nxt_s    = credits_r;
    credit_err_nxt_s = credit_err_r;
    case ({consume, credit_ret})
      2'b10: credits_nxt_s = credits_r - 4'd1;
      2'b01: begin
        if (credits_r == CRED_MAX) begin
          credit_err_nxt_s = 1'b1;
        end else begin
          credits_nxt_s = credits_r + 4'd1;
        end
      end
      default: credits_nxt_s = credits_r;
    endcase
  end

  assign credits    = credits_r;
  assign credit_err = credit_err_r;

endmodule

// File: rtl/fsab_arb2.sv
// Two-requester FSAB arbiter: round-robin request starts, credit-gated,
// with write bursts locking the bus to their owner until the last beat.
module fsab_arb2
  import fsab_arb2_pkg::*;
#(
  parameter int unsigned CREDITS = 4
) (
  input  logic                    fclk,
  input  logic                    fclk_rst_b,

  input  logic                    r0_valid,
  input  logic [FSAB_REQ_HI:0]    r0_mode,
  input  logic [FSAB_DID_HI:0]    r0_did,
  input  logic [FSAB_DID_HI:0]    r0_subdid,
  input  logic [FSAB_ADDR_HI:0]   r0_addr,
  input  logic [FSAB_LEN_HI:0]    r0_len,
  input  logic [FSAB_DATA_HI:0]   r0_data,
  input  logic [FSAB_MASK_HI:0]   r0_mask,
  output logic                    r0_ready,

  input  logic                    r1_valid,
  input  logic [FSAB_REQ_HI:0]    r1_mode,
  input  logic [FSAB_DID_HI:0]    r1_did,
  input  logic [FSAB_DID_HI:0]    r1_subdid,
  input  logic [FSAB_ADDR_HI:0]   r1_addr,
  input  logic [FSAB_LEN_HI:0]    r1_len,
  input  logic [FSAB_DATA_HI:0]   r1_data,
  input  logic [FSAB_MASK_HI:0]   r1_mask,
  output logic                    r1_ready,

  output logic                    fsabo_valid,
  output logic [FSAB_REQ_HI:0]    fsabo_mode,
  output logic [FSAB_DID_HI:0]    fsabo_did,
  output logic [FSAB_DID_HI:0]    fsabo_subdid,
  output logic [FSAB_ADDR_HI:0]   fsabo_addr,
  output logic [FSAB_LEN_HI:0]    fsabo_len,
  output logic [FSAB_DATA_HI:0]   fsabo_data,
  output logic [FSAB_MASK_HI:0]   fsabo_mask,
  input  logic                    fsabo_credit,
  output logic                    credit_err
);

  arb_state_e             state_r;
  arb_state_e             state_nxt_s;
  logic                   owner_r;
  logic                   owner_nxt_s;
  logic [FSAB_LEN_HI:0]   beatsleft_r;
  logic [FSAB_LEN_HI:0]   beatsleft_nxt_s;
  logic                   last_grant_r;
  logic                   last_grant_nxt_s;

  logic                   sel_s;
  logic                   grant_valid_s;
  logic                   start_s;
  logic [3:0]             credits_s;

  fsab_credit_ctr #(
    .CREDITS (CREDITS)
  ) u_credit_ctr (
    .fclk       (fclk),
    .fclk_rst_b (fclk_rst_b),
    .consume    (start_s),
    .credit_ret (fsabo_credit),
    .credits    (credits_s),
    .credit_err (credit_err)
  );

  // Arbiter state registers.
  always_ff @(posedge fclk or negedge fclk_rst_b) begin
    if (!fclk_rst_b) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      beatsleft_r  <= LEN_ZERO;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      beatsleft_r  <= beatsleft_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  // Grant selection: round-robin in IDLE when credits allow, locked to owner in BURST.
  always_comb begin
    sel_s         = 1'b0;
    grant_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (credits_s != 4'd0) begin
          if (r0_valid && r1_valid) begin
            sel_s = ~last_grant_r;
          end else if (r1_valid) begin
            sel_s = 1'b1;
          end else begin
            sel_s = 1'b0;
          end
          grant_valid_s = r0_valid | r1_valid;
        end else begin
          sel_s         = 1'b0;
          grant_valid_s = 1'b0;
        end
      end
      ST_BURST: begin
        sel_s         = owner_r;
        grant_valid_s = owner_r ? r1_valid : r0_valid;
      end
      default: begin
        sel_s         = 1'b0;
        grant_valid_s = 1'b0;
      end
    endcase
  end

  // Zero-latency bus mux onto the merged request bus.
  always_comb begin
    if (sel_s) begin
      fsabo_mode   = r1_mode;
      fsabo_did    = r1_did;
      fsabo_subdid = r1_subdid;
      fsabo_addr   = r1_addr;
      fsabo_len    = r1_len;
      fsabo_data   = r1_data;
      fsabo_mask   = r1_mask;
    end else begin
      fsabo_mode   = r0_mode;
      fsabo_did    = r0_did;
      fsabo_subdid = r0_subdid;
      fsabo_addr   = r0_addr;
      fsabo_len    = r0_len;
      fsabo_data   = r0_data;
      fsabo_mask   = r0_mask;
    end
  end

  // Reset gates the bus directly so nothing is issued while it is held.
  assign fsabo_valid = grant_valid_s & fclk_rst_b;
  assign start_s     = fsabo_valid & (state_r == ST_IDLE);
  assign r0_ready    = fsabo_valid & ~sel_s;
  assign r1_ready    = fsabo_valid & sel_s;

  // Next-state: open a burst on a multi-beat write start, count owner beats down.
  always_comb begin
    state_nxt_s      = state_r;
    owner_nxt_s      = owner_r;
    beatsleft_nxt_s  = beatsleft_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          last_grant_nxt_s = sel_s;
          if (is_multi_beat(fsabo_mode, fsabo_len)) begin
            state_nxt_s     = ST_BURST;
            owner_nxt_s     = sel_s;
            beatsleft_nxt_s = fsabo_len - LEN_ONE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (fsabo_valid) begin
          if (beatsleft_r == LEN_ONE) begin
            state_nxt_s     = ST_IDLE;
            beatsleft_nxt_s = LEN_ZERO;
          end else begin
            beatsleft_nxt_s = beatsleft_r - LEN_ONE;
          end
        end else begin
          beatsleft_nxt_s = beatsleft_r;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        beatsleft_nxt_s = LEN_ZERO;
      end
    endcase
  end

endmodule

// File: doc/fsab_arb2.md
FSAB_ARB2 -- requirements
Module: fsab_arb2

Interface
REQ-001 Parameter CREDITS, default 4, meaning downstream FSAB request credits available after reset (range 1-15).
REQ-002 fclk  in  1  sole clock; all state on rising edge.
REQ-003 fclk_rst_b  in  1  reset, asynchronous, active-low.
REQ-004 rN_valid (N=0,1)  in  1  requester N beat valid.
REQ-005 rN_mode  in  FSAB_REQ_HI+1  requester N mode (FSAB_READ/FSAB_WRITE).
REQ-006 rN_did, rN_subdid  in  FSAB_DID_HI+1 each  requester N device/sub-device ID.
REQ-007 rN_addr  in  FSAB_ADDR_HI+1  requester N address.
REQ-008 rN_len  in  FSAB_LEN_HI+1  requester N burst length in beats.
REQ-009 rN_data  in  FSAB_DATA_HI+1  requester N write data.
REQ-010 rN_mask  in  FSAB_MASK_HI+1  requester N byte mask.
REQ-011 rN_ready  out  1  requester N beat accepted this cycle.
REQ-012 fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len, fsabo_data, fsabo_mask  out  FSAB widths  merged FSAB request bus to FSABMemory.
REQ-013 fsabo_credit  in  1  one-cycle pulse, one credit returned per request.
REQ-014 credit_err  out  1  sticky: credit returned while counter already at CREDITS.

Function
REQ-015 States IDLE, BURST; registered: state, owner (1b), beatsleft (FSAB_LEN_HI+1), credits (4b), last-grant (1b), credit_err.
REQ-016 Request start only in IDLE with credits>0; credits==0 -> all rN_ready=0, fsabo_valid=0.
REQ-017 Round-robin: both valid -> grant the requester not granted last; one valid -> grant it; last-grant updates on each request start.
REQ-018 Bus mux combinational: fsabo_* = granted requester's fields, fsabo_valid = granted rN_valid, rN_ready = fsabo_valid for granted N only; zero-cycle latency.
REQ-019 Request start decrements credits by 1; fsabo_credit increments by 1; both same cycle -> credits unchanged.
REQ-020 Read, or write with len<=1 (len 0 treated as 1): single beat, remain IDLE.
REQ-021 Write with len>1: IDLE->BURST, owner=granted, beatsleft=len-1.
REQ-022 BURST: mux locked to owner regardless of other valid; each owner valid beat decrements beatsleft; beat with beatsleft==1 -> IDLE.
REQ-023 BURST with owner valid low: fsabo_valid=0, state and beatsleft hold (stall, no timeout).
REQ-024 BURST beats consume no credits; fsabo_credit still counted.
REQ-025 fsabo_credit with credits==CREDITS and no same-cycle start: credits hold, credit_err set, cleared only by reset.
REQ-026 Non-driven fsabo_* fields when fsabo_valid=0 are don't-care; bench checks only valid beats.

Reset
REQ-027 fclk_rst_b low: state=IDLE, beatsleft=0, owner=0, last-grant=1 (r0 wins first tie), credits=CREDITS, credit_err=0, hence fsabo_valid=0, r0_ready=r1_ready=0.
REQ-028 Reset mid-BURST aborts burst; no beat issued until reset released; remaining beats of aborted burst are requester's responsibility.

Structure
REQ-029 FSAB widths, FSAB_READ/FSAB_WRITE come from fsab_defines.vh; no new shared constants except CREDITS parameter.
REQ-030 Single module; optional sub-module fsab_credit_ctr for credit counter/error flag.

Verification
REQ-031 Both idle after reset, r0 read addr 0x0 len 8 -> fsabo_valid same cycle, r0_ready=1, credits 4->3.
REQ-032 r0 and r1 reads same cycle, repeated x4 with credits returned -> grants alternate r0,r1,r0,r1.
REQ-033 r1 write len 8 data {16{k}} k=8..1, r0 valid throughout -> 8 contiguous r1 beats, r0_ready=0 until burst ends, then r0 granted.
REQ-034 Owner drops valid for 3 cycles at beat 4 of 8 -> fsabo_valid=0 those cycles, remaining 4 beats delivered, no r0 interleave.
REQ-035 5 reads, CREDITS=4, no credit returns -> 4 issued, 5th stalls; one fsabo_credit pulse -> 5th issues next cycle.
REQ-036 fsabo_credit pulse right after reset -> credit_err=1, credits stay 4; assert reset mid-burst -> all outputs idle, credits=4.
